// File: rtl/switch_instr_issue.sv
// switch_instr_issue: debounces the execute key and captures the switch fields into a one-entry issue buffer.
// Latency: with D = DEBOUNCE_CYCLES, instr_valid rises after edge D+3 counted from the first low key sample.
// Backpressure: valid/ready; a press that finds the buffer full with no handshake on that edge is dropped.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   key_exec_n                  raw execute pushbutton, active low, asynchronous to clk
//   codop, addA, addB_LMM, addC  quasi-static instruction fields from the switch reader
//   instr_ready                 datapath accepts the buffered instruction when instr_valid is also 1
//   instr_valid, instr_*        buffered instruction and its valid flag
//   key_pressed                 debounced key level, 1 = pressed
//   issue_count, drop_count     8-bit wrapping statistics
//
// Optional feature macro: SWITCH_ISSUE_STATS_EN builds the statistics counters;
// without it both counter outputs are tied to zero.
module switch_instr_issue #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_exec_n,
   input  logic [3:0] codop,
   input  logic [3:0] addA,
   input  logic [3:0] addB_LMM,
   input  logic [3:0] addC,
   input  logic       instr_ready,
   output logic       instr_valid,
   output logic [3:0] instr_codop,
   output logic [3:0] instr_addA,
   output logic [3:0] instr_addB_LMM,
   output logic [3:0] instr_addC,
   output logic       key_pressed,
   output logic [7:0] issue_count,
   output logic [7:0] drop_count
);

   typedef enum logic [1:0] {
      ST_UP       = 2'd0,
      ST_DOWN_CHK = 2'd1,
      ST_DOWN     = 2'd2,
      ST_UP_CHK   = 2'd3
   } state_t;

   localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

   // ------------------------------------------------------------------
   // Key synchronizer. Both flops reset to the released level so that a
   // reset never manufactures a press.
   // ------------------------------------------------------------------
   logic r_sync1;
   logic r_sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= key_exec_n;
         r_sync2 <= r_sync1;
      end
   end

   logic w_key_s;
   assign w_key_s = r_sync2;

   // ------------------------------------------------------------------
   // Debounce FSM. key_pressed is a registered output that changes only
   // on the edges that settle into DOWN or back into UP; UP_CHK keeps it
   // high because a bounce during release falls back to DOWN.
   // ------------------------------------------------------------------
   state_t      r_state;
   logic [15:0] r_cnt;
   logic        r_key_pressed;
   logic        w_cnt_done;

   assign w_cnt_done = (r_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_UP;
         r_cnt         <= 16'd0;
         r_key_pressed <= 1'b0;
      end else begin
         case (r_state)
            ST_UP: begin
               if (!w_key_s) begin
                  r_state <= ST_DOWN_CHK;
                  r_cnt   <= 16'd0;
               end
            end
            ST_DOWN_CHK: begin
               if (w_key_s) begin
                  r_state <= ST_UP;
               end else if (w_cnt_done) begin
                  r_state       <= ST_DOWN;
                  r_key_pressed <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            ST_DOWN: begin
               if (w_key_s) begin
                  r_state <= ST_UP_CHK;
                  r_cnt   <= 16'd0;
               end
            end
            ST_UP_CHK: begin
               if (!w_key_s) begin
                  r_state <= ST_DOWN;
               end else if (w_cnt_done) begin
                  r_state       <= ST_UP;
                  r_key_pressed <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: begin
               r_state <= ST_UP;
            end
         endcase
      end
   end

   // The press event is the single edge that leaves DOWN_CHK towards DOWN;
   // the buffer acts on that same edge, so it is decoded from current state.
   logic w_press;
   assign w_press = (r_state == ST_DOWN_CHK) && !w_key_s && w_cnt_done;

   // ------------------------------------------------------------------
   // Single-entry issue buffer.
   // ------------------------------------------------------------------
   logic       r_instr_valid;
   logic [3:0] r_instr_codop;
   logic [3:0] r_instr_addA;
   logic [3:0] r_instr_addB_LMM;
   logic [3:0] r_instr_addC;
   logic       w_hs;
   logic       w_capture;
   logic       w_drop;

   assign w_hs      = r_instr_valid && instr_ready;
   // A full buffer may still take the press when its current entry leaves
   // on the same edge, so back-to-back issue needs no idle cycle.
   assign w_capture = w_press && (!r_instr_valid || w_hs);
   assign w_drop    = w_press && r_instr_valid && !w_hs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr_valid    <= 1'b0;
         r_instr_codop    <= 4'd0;
         r_instr_addA     <= 4'd0;
         r_instr_addB_LMM <= 4'd0;
         r_instr_addC     <= 4'd0;
      end else if (w_capture) begin
         r_instr_valid    <= 1'b1;
         r_instr_codop    <= codop;
         r_instr_addA     <= addA;
         r_instr_addB_LMM <= addB_LMM;
         r_instr_addC     <= addC;
      end else if (w_hs) begin
         // Fields keep their last values; only the valid flag drops.
         r_instr_valid <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Statistics
   // ------------------------------------------------------------------
`ifdef SWITCH_ISSUE_STATS_EN
   logic [7:0] r_issue_count;
   logic [7:0] r_drop_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_issue_count <= 8'd0;
         r_drop_count  <= 8'd0;
      end else begin
         if (w_hs) begin
            r_issue_count <= r_issue_count + 8'd1;
         end
         if (w_drop) begin
            r_drop_count <= r_drop_count + 8'd1;
         end
      end
   end

   assign issue_count = r_issue_count;
   assign drop_count  = r_drop_count;
`else
   logic w_unused_drop;
   assign w_unused_drop = w_drop;
   assign issue_count   = 8'd0;
   assign drop_count    = 8'd0;
`endif

   assign instr_valid    = r_instr_valid;
   assign instr_codop    = r_instr_codop;
   assign instr_addA     = r_instr_addA;
   assign instr_addB_LMM = r_instr_addB_LMM;
   assign instr_addC     = r_instr_addC;
   assign key_pressed    = r_key_pressed;

endmodule
